// File: rtl/costas_deframer.sv
// Deframer for the Costas bit slicer: sync-pair alignment, 8b/10b data decode with
// one-symbol lookahead to mark the last byte, and a registered-output byte FIFO.
module costas_deframer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bitValid,
  input  logic       bitData,
  input  logic       stopIn,
  output logic       pushByte,
  output logic [7:0] Byte,
  output logic       Sync,
  output logic       lastByte,
  output logic       frameErr,
  output logic       ovf
);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  SYNC_A = 10'h0F9;
  localparam logic [9:0]  SYNC_B = 10'h306;
  localparam logic [9:0]  STOP_N = 10'h2BC;
  localparam logic [9:0]  STOP_P = 10'h143;
  localparam logic [AW:0] FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, SYNC2, DATA} state_t;
  state_t state, state_nxt;

  logic [9:0] shreg, sym;
  logic [3:0] bitcnt;
  logic       sym_done, is_stop, dec_ok;
  logic [7:0] dec_byte, hold_byte;
  logic       hold_valid, first_pending;
  logic       wr_en;
  logic [9:0] wr_entry;

  // Symbol layout is abcdei_fghj with 'a' in bit 9; disparity is not checked.
  function automatic logic [8:0] decode_8b10b(input logic [9:0] s);
    logic [4:0] x;
    logic [2:0] y;
    logic       v6, v4;
    x = '0; y = '0; v6 = 1'b1; v4 = 1'b1;
    case (s[9:4])
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              v6 = 1'b0;
    endcase
    case (s[3:0])
      4'b1011, 4'b0100:                   y = 3'd0;
      4'b1001:                            y = 3'd1;
      4'b0101:                            y = 3'd2;
      4'b1100, 4'b0011:                   y = 3'd3;
      4'b1101, 4'b0010:                   y = 3'd4;
      4'b1010:                            y = 3'd5;
      4'b0110:                            y = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
      default:                            v4 = 1'b0;
    endcase
    return {v6 & v4, y, x};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:  if (bitValid && sym == SYNC_A) state_nxt = SYNC2;
      SYNC2: if (sym_done) begin
               if (sym == SYNC_B) state_nxt = DATA;
               else               state_nxt = HUNT;
             end
      DATA:  if (sym_done && (is_stop || !dec_ok)) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    sym                = {bitData, shreg[9:1]};
    sym_done           = bitValid && (state != HUNT) && (bitcnt == 4'd9);
    is_stop            = (sym == STOP_N) || (sym == STOP_P);
    {dec_ok, dec_byte} = decode_8b10b(sym);
  end

  // Stop symbols are tested before decode: they are disparity-illegal forms of D.31.3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg         <= '0;
      bitcnt        <= '0;
      hold_byte     <= '0;
      hold_valid    <= 1'b0;
      first_pending <= 1'b0;
      wr_en         <= 1'b0;
      wr_entry      <= '0;
      frameErr      <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      frameErr <= 1'b0;
      if (bitValid) begin
        shreg  <= sym;
        bitcnt <= (state == HUNT || bitcnt == 4'd9) ? '0 : bitcnt + 4'd1;
      end
      if (sym_done && state == SYNC2 && sym == SYNC_B) begin
        first_pending <= 1'b1;
        hold_valid    <= 1'b0;
      end
      if (sym_done && state == DATA) begin
        if (is_stop) begin
          wr_en         <= hold_valid;
          wr_entry      <= {first_pending, 1'b1, hold_byte};
          hold_valid    <= 1'b0;
          first_pending <= 1'b0;
        end else if (dec_ok) begin
          wr_en      <= hold_valid;
          wr_entry   <= {first_pending, 1'b0, hold_byte};
          hold_byte  <= dec_byte;
          hold_valid <= 1'b1;
          if (hold_valid) first_pending <= 1'b0;
        end else begin
          hold_valid    <= 1'b0;
          first_pending <= 1'b0;
          frameErr      <= 1'b1;
        end
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_nxt, remain;
  logic          do_rd, do_wr;

  always_comb begin
    do_rd     = (count != '0) && !stopIn;
    do_wr     = wr_en && ((count != FULL) || do_rd);
    remain    = count - (AW+1)'(do_rd);
    count_nxt = remain + (AW+1)'(do_wr);
    rd_nxt    = rd_ptr + AW'(do_rd);
  end

  // Head registers load the incoming entry directly when it lands in an emptied FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pushByte <= 1'b0;
      Byte     <= '0;
      Sync     <= 1'b0;
      lastByte <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_nxt;
      count    <= count_nxt;
      pushByte <= (count_nxt != '0);
      if (count_nxt != '0) {Sync, lastByte, Byte} <= (remain == '0) ? wr_entry : mem[rd_nxt];
      if (wr_en && !do_wr) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: tb/tb_costas_deframer.sv
// Randomized bench for costas_deframer: frames are 8b/10b encoded with running disparity
// and expected FIFO output is derived frame-by-frame from the framing rules.
module tb_costas_deframer;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset, bitValid, bitData, stopIn;
  logic       pushByte, Sync, lastByte, frameErr, ovf;
  logic [7:0] Byte;

  costas_deframer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bitValid(bitValid), .bitData(bitData), .stopIn(stopIn),
    .pushByte(pushByte), .Byte(Byte), .Sync(Sync), .lastByte(lastByte),
    .frameErr(frameErr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned err_pulses = 0, exp_err = 0;
  int unsigned stop_mode = 0, burst = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  win = '0;
  bit          rd_pos = 1'b0;

  logic [5:0] tab6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                            6'b011110, 6'b101011};
  logic [3:0] tab4 [8]  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RD- table entries; the RD+ form is the complement for unbalanced codes and D.7 / D.x.3.
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    x  = d[4:0];
    y  = d[7:5];
    s6 = tab6[x];
    if (rd_pos && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
    if ($countones(s6) != 3) rd_pos = !rd_pos;
    if (y == 3'd7 && ((!rd_pos && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                      ( rd_pos && (x == 5'd11 || x == 5'd13 || x == 5'd14)))) s4 = 4'b0111;
    else s4 = tab4[y];
    if (rd_pos && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
    if ($countones(s4) != 2) rd_pos = !rd_pos;
    return {s6, s4};
  endfunction

  task automatic send_bit(input logic b);
    int unsigned gap;
    @(negedge clk);
    bitValid = 1'b1;
    bitData  = b;
    win      = {b, win[9:1]};
    gap      = $urandom_range(0, 2);
    if (gap != 0) begin
      @(negedge clk);
      bitValid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) send_bit(s[i]);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    bitValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Noise never forms 0F9; ten trailing ones cannot combine with the sync word into a false 0F9.
  task automatic preamble(input int unsigned noise_n);
    logic b;
    for (int unsigned i = 0; i < noise_n; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({b, win[9:1]} == 10'h0F9) b = ~b;
      send_bit(b);
    end
    for (int i = 0; i < 10; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data [$], input logic [9:0] term,
                            input int unsigned noise_n, input int unsigned keep_lim);
    bit          good;
    int unsigned n, k;
    good = (term == 10'h2BC) || (term == 10'h143);
    n    = data.size();
    k    = good ? n : ((n == 0) ? 0 : n - 1);
    if (k > keep_lim) k = keep_lim;
    for (int unsigned i = 0; i < k; i++)
      exp_q.push_back({(i == 0), (good && i == n - 1), data[i]});
    if (!good) exp_err++;
    preamble(noise_n);
    send_sym(10'h0F9);
    send_sym(10'h306);
    foreach (data[i]) send_sym(enc(data[i]));
    send_sym(term);
    idle(2);
  endtask

  function automatic logic [9:0] rand_stop();
    return ($urandom_range(0, 1) != 0) ? 10'h2BC : 10'h143;
  endfunction

  task automatic wait_drain(input string tag);
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (12) @(negedge clk);
    check(tag, exp_q.size(), 0);
    check({tag, "_err"}, err_pulses, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"}, pushByte, 0);
    check({tag, "_byte"}, Byte, 0);
    check({tag, "_sync"}, Sync, 0);
    check({tag, "_last"}, lastByte, 0);
    check({tag, "_ferr"}, frameErr, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    stopIn = 1'b0;
    forever begin
      @(negedge clk);
      if (stop_mode == 0) stopIn = 1'b0;
      else if (stop_mode == 2) stopIn = 1'b1;
      else if (burst > 0) begin
        stopIn = 1'b1;
        burst--;
      end else begin
        stopIn = 1'b0;
        if ($urandom_range(0, 3) == 0) burst = $urandom_range(0, 10);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (frameErr) err_pulses++;
        if (pushByte && !stopIn)
          check("output_byte", {22'd0, Sync, lastByte, Byte},
                (exp_q.size() != 0) ? {22'd0, exp_q.pop_front()} : 32'h1000);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    int unsigned len;
    logic [9:0] terms [5] = '{10'h2BC, 10'h143, 10'h0F9, 10'h3FF, 10'h000};

    reset    = 1'b1;
    bitValid = 1'b0;
    bitData  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b0;

    q = {8'h00, 8'h01, 8'h02};
    send_frame(q, rand_stop(), 20, 1000);
    wait_drain("three_bytes");

    q = {};
    send_frame(q, rand_stop(), 0, 1000);
    q = {8'h55};
    send_frame(q, rand_stop(), 0, 1000);
    wait_drain("empty_then_55");

    stop_mode = 1;
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    send_frame(q, rand_stop(), 5, 1000);
    wait_drain("full_range");
    stop_mode = 0;

    preamble(5);
    send_sym(10'h0F9);
    send_sym(enc(8'h12));
    q = {8'hAA};
    send_frame(q, rand_stop(), 3, 1000);
    wait_drain("bad_sync");

    q = {8'h11, 8'h22};
    send_frame(q, 10'h0F9, 4, 1000);
    wait_drain("abort_0f9");

    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(0, 6);
      q = {};
      for (int unsigned i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
      send_frame(q, terms[$urandom_range(0, 4)], $urandom_range(0, 15), 1000);
    end
    wait_drain("random_frames");

    stop_mode = 2;
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom_range(0, 255)));
    send_frame(q, rand_stop(), 2, DEPTH);
    repeat (5) @(negedge clk);
    check("ovf_set", ovf, 1);
    check("full_push", pushByte, 1);
    stop_mode = 0;
    wait_drain("overflow");

    stop_mode = 2;
    preamble(3);
    send_sym(10'h0F9);
    send_sym(10'h306);
    send_sym(enc(8'h3C));
    send_sym(enc(8'hC3));
    idle(3);
    check("mid_push", pushByte, 1);
    @(negedge clk);
    reset = 1'b1;
    win   = '0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    stop_mode = 0;
    send_sym(10'h2BC);
    idle(20);
    check("post_reset_push", pushByte, 0);
    q = {};
    len = $urandom_range(1, 4);
    for (int unsigned i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    send_frame(q, rand_stop(), 6, 1000);
    wait_drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/costas_deframer.md
COSTAS_DEFRAMER -- requirements
Module: costas_deframer

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 bitValid  input  1  one-cycle strobe; recovered bit from the upstream Costas bit slicer is valid.
REQ-004 bitData  input  1  recovered bit value, sampled only when bitValid=1.
REQ-005 stopIn  input  1  downstream backpressure; an output entry is consumed only when pushByte=1 and stopIn=0.
REQ-006 pushByte  output  1  output FIFO non-empty; Byte/Sync/lastByte are valid.
REQ-007 Byte  output  8  decoded data byte at FIFO head.
REQ-008 Sync  output  1  head byte is the first data byte of a frame.
REQ-009 lastByte  output  1  head byte is the last data byte of a frame.
REQ-010 frameErr  output  1  one-cycle pulse when a frame is aborted.
REQ-011 ovf  output  1  sticky flag; a byte was dropped on a full FIFO.
REQ-012 FIFO_DEPTH  parameter, default 8, output FIFO entries (power of 2).

Function
REQ-013 Bits SHALL shift into a 10-bit register so the first received bit of a symbol lands in symbol bit 0.
REQ-014 States SHALL be HUNT, SYNC2, DATA; reset state HUNT.
REQ-015 HUNT: on every bitValid, compare the register with 10'h0F9; on match, clear the bit counter and go to SYNC2. This is the only bit-granular alignment point.
REQ-016 SYNC2: after 10 more bits, a symbol of 10'h306 SHALL go to DATA with firstPending=1 and holdValid=0; any other symbol SHALL return to HUNT with no frameErr.
REQ-017 DATA: every 10 bits form one symbol.
REQ-018 Stop symbols are 10'h2BC and 10'h143. Both SHALL be accepted regardless of running disparity.
REQ-019 Data symbols SHALL be decoded with the shared 8b/10b decode function. Disparity errors are ignored. Only invalid codes are errors.
REQ-020 One-symbol lookahead: a decoded byte is held, not written, until the next symbol arrives.
REQ-021 Next symbol is a data symbol: write the held byte with lastByte=0, then hold the new byte.
REQ-022 Next symbol is a stop symbol: write the held byte with lastByte=1, then go to HUNT.
REQ-023 Sync SHALL be 1 on the first byte written in a frame and 0 on all later bytes; one-byte frames carry Sync=1 and lastByte=1.
REQ-024 Empty frame (sync pair followed directly by stop) SHALL write nothing and return to HUNT.
REQ-025 Invalid code in DATA SHALL discard the held byte, pulse frameErr for 1 cycle and return to HUNT. Bytes already written stay in the FIFO.
REQ-026 A new 10'h0F9 seen in DATA SHALL have no special meaning; it decodes as an invalid code per REQ-025.
REQ-027 FIFO write latency SHALL be 1 clk after the bitValid that completes the symbol. pushByte SHALL rise the cycle after the write.
REQ-028 Simultaneous write and consume SHALL both take effect. A consume on an empty FIFO SHALL be a no-op.
REQ-029 Write to a full FIFO with no same-cycle consume SHALL drop the byte and set ovf; ovf clears only on reset.
REQ-030 Outputs SHALL be registered: Byte/Sync/lastByte driven from the FIFO head, and stable while stopIn=1.

Reset
REQ-031 Reset SHALL asynchronously force HUNT, empty FIFO, bit counter 0, shift register 0, hold and firstPending cleared.
REQ-032 Output reset values: pushByte=0, Byte=8'h00, Sync=0, lastByte=0, frameErr=0, ovf=0.
REQ-033 Reset mid-frame SHALL discard all state; the next output needs a fresh 0F9/306 sync.

Verification
REQ-034 Random bits, then 0F9, 306, encode(0x00), encode(0x01), encode(0x02), stop -> three bytes 00/01/02; Sync on 00, lastByte on 02 only.
REQ-035 0F9, 306, stop, then 0F9, 306, encode(0x55), stop -> exactly one output: Byte=55, Sync=1, lastByte=1.
REQ-036 256-byte frame 00..FF with stopIn randomly high 0-10 cycles -> all 256 bytes in order; Sync on 00, lastByte on FF; nothing lost while stopIn=1.
REQ-037 0F9 then a non-306 symbol, then a valid frame with byte AA -> no output from the bad sync, no frameErr; AA delivered with Sync=1, lastByte=1.
REQ-038 Frame 11, 22, invalid code, ... -> 11 delivered (Sync=1, lastByte=0); 22 discarded; frameErr pulses once; state returns to HUNT.
REQ-039 stopIn held 1 while a 10-byte frame arrives, FIFO_DEPTH=8 -> ovf=1, first 8 bytes retained in order; reset mid-frame -> all outputs at reset values.
